layer_scheduler: RTL and testbench
==================================

Name: layer_scheduler

Overview:
- Sequences the convolution datapath through NUM_LAYER+1 conv layers for each of NUM_IMG images.
- Issues a per-layer start pulse with the current feature-map dimensions.
- Gates the pixel stream into the datapath input FIFO, counting exactly width*height words per layer.
- Waits for the datapath's layer-done indication, then advances. It halves the dimensions after any layer flagged as followed by 2x2 max-pooling.

Parameters:
- WIDTH, 224, input image width in pixels.
- HEIGHT, 224, input image height in pixels.
- NUM_IMG, 1, number of images per run.
- NUM_LAYER, 13, index of the last conv layer (number of conv layers minus 1).
- POOL_MASK, 14'h124A, bit i = 1 means layer i is followed by 2x2 max-pool (layers 1,3,6,9,12).

Ports:
- clk  input  1  system clock
- resetn  input  1  asynchronous active-low reset
- run  input  1  start request, sampled in IDLE
- src_valid  input  1  upstream pixel word available
- src_ready  output  1  scheduler accepts pixel this cycle
- src_sel  output  1  0 = external image source (layer 0), 1 = feedback buffer (layers >= 1)
- fifo_full  input  1  datapath input FIFO full
- fifo_wrreq  output  1  write strobe to datapath input FIFO
- layer_done  input  1  single-cycle pulse: datapath finished current layer
- layer_start  output  1  single-cycle pulse at start of each layer
- layer_idx  output  4  current layer index
- img_idx  output  16  current image index
- cur_width  output  16  current layer feature-map width
- cur_height  output  16  current layer feature-map height
- busy  output  1  high from leaving IDLE until DONE
- done  output  1  single-cycle pulse after last layer of last image

Behaviour:
- Reset (asynchronous, resetn=0) values:
  - All outputs 0, except cur_width=WIDTH and cur_height=HEIGHT.
  - State IDLE; pixel counter, done-latch and indices cleared.
- Reset mid-operation aborts immediately to these values. No partial-layer resumption.
- States:
  - IDLE: busy=0. On run=1, go to START with layer_idx=0, img_idx=0, dims=WIDTH/HEIGHT.
  - START: one cycle. layer_start=1. Clear pixel counter and done-latch. Go to FEED.
  - FEED: the beat condition is xfer = src_valid & ~fifo_full & (pix_cnt < cur_width*cur_height).
    - src_ready = fifo_wrreq = xfer, combinational in FEED only.
    - Each xfer increments pix_cnt (32-bit).
    - When pix_cnt reaches cur_width*cur_height (the cycle after the last xfer), go to WAIT.
  - WAIT: no transfers (src_ready=0, fifo_wrreq=0). When done-latch=1 or layer_done=1, go to ADVANCE.
  - ADVANCE: one cycle.
    - If POOL_MASK[layer_idx], cur_width>>=1 and cur_height>>=1 (truncating).
    - If layer_idx<NUM_LAYER: layer_idx++, go to START.
    - Else if img_idx<NUM_IMG-1: img_idx++, layer_idx=0, dims=WIDTH/HEIGHT, go to START.
    - Else go to DONE.
  - DONE: one cycle. done=1. Go to IDLE. busy deasserts in IDLE.
- layer_done latching:
  - A layer_done pulse in FEED (early completion, e.g. pipelined drain) sets the sticky done-latch.
  - A pulse in WAIT is consumed directly.
  - Pulses in IDLE/START/ADVANCE/DONE are ignored.
  - A pulse coincident with START is ignored, because START clears the latch.
- src_sel = (layer_idx != 0), registered with layer_idx.
- Dimension product is a 32-bit unsigned multiply of the registered dims, registered in START.
- A zero dimension skips FEED (count already satisfied) and goes directly to WAIT.
- run while busy is ignored.
- fifo_full=1 with src_valid=1 stalls: no wrreq and no count change.
- Throughput: 1 pixel/cycle when unstalled.
- Per-layer overhead: START 1 cycle + ADVANCE 1 cycle + the WAIT duration.

Test Plan:
- WIDTH=4, HEIGHT=4, NUM_LAYER=1, POOL_MASK=2'b01, src_valid=1, fifo_full=0, layer_done 3 cycles after WAIT entry:
  - exactly 16 wrreq on layer 0, then 4 on layer 1 (dims 2x2).
  - layer_start pulses twice, done pulses once.
  - src_sel is 0 then 1.
- Backpressure: toggle fifo_full every cycle on a 4x4 layer -> exactly 16 wrreq, never asserted while fifo_full=1, 32 FEED cycles.
- Early layer_done: pulse layer_done during FEED at pix_cnt=5 -> FEED still completes 16 words, WAIT lasts 1 cycle, ADVANCE follows.
- NUM_IMG=2, NUM_LAYER=0, WIDTH=HEIGHT=2 -> img_idx goes 0 then 1, dims restored to 2x2 for image 1, done after second layer_done, 8 total wrreq.
- Async reset: drop resetn mid-FEED at pix_cnt=7 -> outputs immediately at reset values. Reassert resetn and pulse run -> full 16-word layer 0 restarts.
- Default parameters, 14 layers -> cur_width sequence 224,224,112,112,56,56,56,28,28,28,14,14,14,7 and layer_start count=14.

Source files
------------

// File: rtl/layer_scheduler.sv
// Per-image, per-layer sequencer for the conv datapath: issues layer starts,
// meters width*height pixel words into the datapath FIFO and tracks pooled dims.
module layer_scheduler #(
    parameter int unsigned WIDTH     = 224,
    parameter int unsigned HEIGHT    = 224,
    parameter int unsigned NUM_IMG   = 1,
    parameter int unsigned NUM_LAYER = 13,
    parameter logic [15:0] POOL_MASK = 16'h124A
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        run,
    input  logic        src_valid,
    output logic        src_ready,
    output logic        src_sel,
    input  logic        fifo_full,
    output logic        fifo_wrreq,
    input  logic        layer_done,
    output logic        layer_start,
    output logic [3:0]  layer_idx,
    output logic [15:0] img_idx,
    output logic [15:0] cur_width,
    output logic [15:0] cur_height,
    output logic        busy,
    output logic        done
);
    typedef enum logic [2:0] {S_IDLE, S_START, S_FEED, S_WAIT, S_ADV, S_DONE} state_t;

    localparam logic [15:0] W0         = 16'(WIDTH);
    localparam logic [15:0] H0         = 16'(HEIGHT);
    localparam logic [3:0]  LAST_LAYER = 4'(NUM_LAYER);
    localparam logic [15:0] LAST_IMG   = 16'(NUM_IMG - 1);

    state_t      state_q, state_d;
    logic [3:0]  layer_q, layer_d;
    logic [15:0] img_q, img_d;
    logic [15:0] width_q, width_d;
    logic [15:0] height_q, height_d;
    logic [31:0] pix_cnt_q, pix_cnt_d;
    logic [31:0] npix_q, npix_d;
    logic        dlatch_q, dlatch_d;
    logic        src_sel_q, src_sel_d;
    logic        xfer;
    logic [31:0] dim_prod;

    assign dim_prod = {16'd0, width_q} * {16'd0, height_q};

    always_comb begin
        state_d   = state_q;
        layer_d   = layer_q;
        img_d     = img_q;
        width_d   = width_q;
        height_d  = height_q;
        pix_cnt_d = pix_cnt_q;
        npix_d    = npix_q;
        dlatch_d  = dlatch_q;
        xfer      = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) begin
                    state_d  = S_START;
                    layer_d  = 4'd0;
                    img_d    = 16'd0;
                    width_d  = W0;
                    height_d = H0;
                end
            end
            S_START: begin
                pix_cnt_d = 32'd0;
                dlatch_d  = 1'b0;
                npix_d    = dim_prod;
                // An empty feature map has nothing to stream.
                state_d   = (dim_prod == 32'd0) ? S_WAIT : S_FEED;
            end
            S_FEED: begin
                xfer = src_valid & ~fifo_full & (pix_cnt_q < npix_q);
                if (xfer) pix_cnt_d = pix_cnt_q + 32'd1;
                // Datapath may finish draining before the last word is metered in.
                if (layer_done) dlatch_d = 1'b1;
                if (pix_cnt_d == npix_q) state_d = S_WAIT;
            end
            S_WAIT: begin
                if (dlatch_q || layer_done) state_d = S_ADV;
            end
            S_ADV: begin
                if (POOL_MASK[layer_q]) begin
                    width_d  = width_q >> 1;
                    height_d = height_q >> 1;
                end
                if (layer_q < LAST_LAYER) begin
                    layer_d = layer_q + 4'd1;
                    state_d = S_START;
                end else if (img_q < LAST_IMG) begin
                    img_d    = img_q + 16'd1;
                    layer_d  = 4'd0;
                    width_d  = W0;
                    height_d = H0;
                    state_d  = S_START;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        src_sel_d = (layer_d != 4'd0);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= S_IDLE;
            layer_q   <= 4'd0;
            img_q     <= 16'd0;
            width_q   <= W0;
            height_q  <= H0;
            pix_cnt_q <= 32'd0;
            npix_q    <= 32'd0;
            dlatch_q  <= 1'b0;
            src_sel_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            layer_q   <= layer_d;
            img_q     <= img_d;
            width_q   <= width_d;
            height_q  <= height_d;
            pix_cnt_q <= pix_cnt_d;
            npix_q    <= npix_d;
            dlatch_q  <= dlatch_d;
            src_sel_q <= src_sel_d;
        end
    end

    assign src_ready   = xfer;
    assign fifo_wrreq  = xfer;
    assign src_sel     = src_sel_q;
    assign layer_start = (state_q == S_START);
    assign layer_idx   = layer_q;
    assign img_idx     = img_q;
    assign cur_width   = width_q;
    assign cur_height  = height_q;
    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
endmodule

// File: tb/tb_layer_scheduler.sv
// Bench for layer_scheduler: four differently-sized instances share stimulus; a
// layer-list model predicts dims, word counts and start/done spacing per layer.
module tb_layer_scheduler;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic [3:0] run = '0;
    logic src_valid = 1'b0, fifo_full = 1'b0, layer_done = 1'b0;
    logic [3:0] src_ready, src_sel, wrreq, lstart, busy, done;
    logic [3:0]  lidx [4];
    logic [15:0] iidx [4];
    logic [15:0] cw [4];
    logic [15:0] ch [4];

    always #5 clk = ~clk;

    layer_scheduler #(.WIDTH(4), .HEIGHT(4), .NUM_IMG(1), .NUM_LAYER(1), .POOL_MASK(16'h0001)) u_a (
        .clk(clk), .resetn(resetn), .run(run[0]), .src_valid(src_valid), .src_ready(src_ready[0]),
        .src_sel(src_sel[0]), .fifo_full(fifo_full), .fifo_wrreq(wrreq[0]), .layer_done(layer_done),
        .layer_start(lstart[0]), .layer_idx(lidx[0]), .img_idx(iidx[0]), .cur_width(cw[0]),
        .cur_height(ch[0]), .busy(busy[0]), .done(done[0]));
    layer_scheduler #(.WIDTH(2), .HEIGHT(2), .NUM_IMG(2), .NUM_LAYER(0), .POOL_MASK(16'h0001)) u_b (
        .clk(clk), .resetn(resetn), .run(run[1]), .src_valid(src_valid), .src_ready(src_ready[1]),
        .src_sel(src_sel[1]), .fifo_full(fifo_full), .fifo_wrreq(wrreq[1]), .layer_done(layer_done),
        .layer_start(lstart[1]), .layer_idx(lidx[1]), .img_idx(iidx[1]), .cur_width(cw[1]),
        .cur_height(ch[1]), .busy(busy[1]), .done(done[1]));
    layer_scheduler #(.WIDTH(28), .HEIGHT(28), .NUM_IMG(1), .NUM_LAYER(13), .POOL_MASK(16'h124A)) u_c (
        .clk(clk), .resetn(resetn), .run(run[2]), .src_valid(src_valid), .src_ready(src_ready[2]),
        .src_sel(src_sel[2]), .fifo_full(fifo_full), .fifo_wrreq(wrreq[2]), .layer_done(layer_done),
        .layer_start(lstart[2]), .layer_idx(lidx[2]), .img_idx(iidx[2]), .cur_width(cw[2]),
        .cur_height(ch[2]), .busy(busy[2]), .done(done[2]));
    layer_scheduler u_d (
        .clk(clk), .resetn(resetn), .run(run[3]), .src_valid(src_valid), .src_ready(src_ready[3]),
        .src_sel(src_sel[3]), .fifo_full(fifo_full), .fifo_wrreq(wrreq[3]), .layer_done(layer_done),
        .layer_start(lstart[3]), .layer_idx(lidx[3]), .img_idx(iidx[3]), .cur_width(cw[3]),
        .cur_height(ch[3]), .busy(busy[3]), .done(done[3]));

    typedef struct {
        int inst; int nimg; int nl; int w; int h; logic [15:0] mask;
        int valid_pct; int full_mode; int early_mode; int dly;
        int exp_starts; int exp_wr;
    } scn_t;
    typedef struct { int img; int layer; int w; int h; } lyr_t;
    typedef struct { int w; int h; } rst_t;

    int n_tests = 0, n_fail = 0;
    rst_t rst_tab [4];
    lyr_t exp_q [$];

    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("%s_busy%0d", tag, k), busy[k], 0);
            chk($sformatf("%s_done%0d", tag, k), done[k], 0);
            chk($sformatf("%s_start%0d", tag, k), lstart[k], 0);
            chk($sformatf("%s_wrreq%0d", tag, k), wrreq[k], 0);
            chk($sformatf("%s_ready%0d", tag, k), src_ready[k], 0);
            chk($sformatf("%s_sel%0d", tag, k), src_sel[k], 0);
            chk($sformatf("%s_lidx%0d", tag, k), lidx[k], 0);
            chk($sformatf("%s_iidx%0d", tag, k), iidx[k], 0);
            chk($sformatf("%s_w%0d", tag, k), cw[k], rst_tab[k].w);
            chk($sformatf("%s_h%0d", tag, k), ch[k], rst_tab[k].h);
        end
    endtask

    // Expected layer list straight from the pooling rule.
    task automatic build_model(input scn_t s);
        int w, h;
        exp_q.delete();
        for (int img = 0; img < s.nimg; img++) begin
            w = s.w; h = s.h;
            for (int l = 0; l <= s.nl; l++) begin
                exp_q.push_back('{img, l, w, h});
                if (s.mask[l]) begin w = w / 2; h = h / 2; end
            end
        end
    endtask

    task automatic run_scn(input scn_t s, input string tag);
        int a, li, cnt, npix, feed_done, feed_end, dly, sent, early, early_at;
        int lstart_cyc, nst, nwr, nrdy, finished, span;
        lyr_t e;
        a = s.inst; li = -1; cnt = 0; npix = 0; feed_done = 0; feed_end = 0; dly = 0;
        sent = 0; early = 0; early_at = -1; lstart_cyc = 0; nst = 0; nwr = 0; nrdy = 0; finished = 0;
        build_model(s);
        for (int cyc = 0; cyc < 10000 && finished == 0; cyc++) begin
            @(posedge clk); #1;
            run[a] = (cyc == 0) || (li >= 0 && cnt > 0 && cnt < npix && $urandom_range(0, 7) == 0);
            src_valid = (int'($urandom_range(0, 99)) < s.valid_pct);
            case (s.full_mode)
                1: fifo_full = (li >= 0) && ((cyc - lstart_cyc) % 2 == 1);
                2: fifo_full = ($urandom_range(0, 3) == 0);
                default: fifo_full = 1'b0;
            endcase
            layer_done = 1'b0;
            if (li >= 0 && sent == 0) begin
                if (feed_done != 0 && cyc == feed_end + 1 + dly) begin
                    layer_done = 1'b1; sent = 1;
                end else if (feed_done == 0 && cnt == early_at) begin
                    layer_done = 1'b1; sent = 1; early = 1;
                end
            end
            @(negedge clk);
            if (fifo_full || !src_valid) chk({tag, "_wr_blocked"}, wrreq[a], 0);
            if (src_ready[a]) nrdy++;
            if (wrreq[a]) begin
                cnt++; nwr++;
                if (cnt > npix) chk({tag, "_wr_overrun"}, cnt, npix);
                if (cnt == npix) begin
                    feed_done = 1; feed_end = cyc;
                    if (s.valid_pct == 100 && s.full_mode != 2) begin
                        span = (s.full_mode == 1) ? 2 * npix : npix;
                        chk({tag, "_feed_span"}, cyc - lstart_cyc, span);
                    end
                end
            end
            if (lstart[a]) begin
                if (li >= 0) begin
                    chk({tag, "_layer_words"}, cnt, npix);
                    chk({tag, "_adv_gap"}, cyc - feed_end, early != 0 ? 3 : 3 + dly);
                end
                li++; nst++;
                if (li >= exp_q.size()) begin
                    chk({tag, "_extra_start"}, li, exp_q.size() - 1);
                    finished = 1;
                end else begin
                    e = exp_q[li];
                    chk({tag, "_layer_idx"}, lidx[a], e.layer);
                    chk({tag, "_img_idx"}, iidx[a], e.img);
                    chk({tag, "_cur_width"}, cw[a], e.w);
                    chk({tag, "_cur_height"}, ch[a], e.h);
                    chk({tag, "_src_sel"}, src_sel[a], (e.layer != 0) ? 1 : 0);
                    cnt = 0; npix = e.w * e.h; sent = 0; early = 0; lstart_cyc = cyc;
                    feed_done = (npix == 0) ? 1 : 0; feed_end = cyc;
                    dly = (s.dly >= 0) ? s.dly : int'($urandom_range(0, 4));
                    early_at = -1;
                    if (s.early_mode == 1 && npix > 5) early_at = 5;
                    else if (s.early_mode == 2 && npix > 0 && $urandom_range(0, 1) == 1)
                        early_at = int'($urandom_range(0, npix - 1));
                end
            end
            if (done[a]) begin
                chk({tag, "_done_layer"}, li, exp_q.size() - 1);
                chk({tag, "_done_words"}, cnt, npix);
                chk({tag, "_done_gap"}, cyc - feed_end, early != 0 ? 3 : 3 + dly);
                chk({tag, "_busy_at_done"}, busy[a], 1);
                finished = 1;
            end else if (li >= 0) begin
                chk({tag, "_busy"}, busy[a], 1);
            end
        end
        chk({tag, "_finished"}, finished, 1);
        chk({tag, "_starts"}, nst, s.exp_starts);
        chk({tag, "_wrreq_total"}, nwr, s.exp_wr);
        chk({tag, "_ready_total"}, nrdy, s.exp_wr);
        run = '0; layer_done = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            src_valid = $urandom_range(0, 1) == 1;
            fifo_full = 1'b0;
            @(negedge clk);
            chk({tag, "_idle_busy"}, busy[a], 0);
            chk({tag, "_idle_start"}, lstart[a], 0);
            chk({tag, "_idle_done"}, done[a], 0);
            chk({tag, "_idle_wrreq"}, wrreq[a], 0);
        end
    endtask

    initial begin
        scn_t scn [8];
        int got;
        rst_tab[0] = '{4, 4};
        rst_tab[1] = '{2, 2};
        rst_tab[2] = '{28, 28};
        rst_tab[3] = '{224, 224};
        //         inst img nl  w   h   mask      vld full early dly starts wr
        scn[0] = '{0,   1,  1,  4,  4,  16'h0001, 100, 0,   0,    3,  2,     20};
        scn[1] = '{0,   1,  1,  4,  4,  16'h0001, 100, 1,   0,    0,  2,     20};
        scn[2] = '{0,   1,  1,  4,  4,  16'h0001, 100, 0,   1,    0,  2,     20};
        scn[3] = '{1,   2,  0,  2,  2,  16'h0001, 100, 0,   0,    2,  2,     8};
        scn[4] = '{2,   1,  13, 28, 28, 16'h124A, 100, 0,   0,    0,  14,    2137};
        scn[5] = '{0,   1,  1,  4,  4,  16'h0001, 70,  2,   2,    -1, 2,     20};
        scn[6] = '{1,   2,  0,  2,  2,  16'h0001, 70,  2,   2,    -1, 2,     8};
        scn[7] = '{2,   1,  13, 28, 28, 16'h124A, 80,  2,   2,    -1, 14,    2137};

        #12;
        check_reset("rst");
        @(negedge clk); resetn = 1'b1;

        for (int i = 0; i < 5; i++) run_scn(scn[i], $sformatf("vec%0d", i));

        // Async reset partway through layer 0, then a clean full restart.
        got = 0;
        src_valid = 1'b1; fifo_full = 1'b0; layer_done = 1'b0;
        for (int cyc = 0; cyc < 50 && got < 7; cyc++) begin
            @(posedge clk); #1;
            run[0] = (cyc == 0);
            @(negedge clk);
            if (wrreq[0]) got++;
        end
        chk("midrst_words_before", got, 7);
        run = '0;
        #2 resetn = 1'b0;
        #1 check_reset("midrst");
        @(negedge clk);
        chk("midrst_held_wrreq", wrreq[0], 0);
        chk("midrst_held_busy", busy[0], 0);
        resetn = 1'b1;
        run_scn(scn[0], "restart");

        for (int r = 0; r < 4; r++) begin
            run_scn(scn[5], $sformatf("rndA%0d", r));
            run_scn(scn[6], $sformatf("rndB%0d", r));
        end
        run_scn(scn[7], "rndC");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
